// File: rtl/jts16_obj_buffer.sv
// Double-buffered sprite line buffer: the draw stage fills one bank while the other
// is streamed to the mixer at pixel rate and erased behind the read pointer.
module jts16_obj_buffer #(
  parameter int unsigned DW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hstart,
  input  logic [DW-1:0] bf_data,
  input  logic          bf_we,
  input  logic [8:0]    bf_addr,
  input  logic          pxl_cen,
  input  logic [8:0]    hdump,
  output logic [DW-1:0] pxl,
  output logic          ready
);

  localparam logic [DW-1:0] Transp = {DW{1'b1}};

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e      state_q, state_d;
  logic [8:0]  clr_addr_q, clr_addr_d;
  logic        clr_done_q, clr_done_d;
  logic        line_q, line_d;
  logic        ready_q, ready_d;

  logic          rd_valid_q;
  logic [8:0]    rd_addr_q;
  logic          rd_bank_q;
  logic          rd_en;
  logic [DW-1:0] pxl_q;
  logic [DW-1:0] rdata_a, rdata_b;

  logic [DW-1:0] mem_a [512];
  logic [DW-1:0] mem_b [512];
  logic [1:0]    mem_we;
  logic [8:0]    mem_waddr [2];
  logic [DW-1:0] mem_wdata [2];

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_done_d = clr_done_q;
    line_d     = line_q;
    ready_d    = ready_q;
    unique case (state_q)
      StInit: begin
        // clr_done marks that address 511 was written; RUN starts one cycle later
        if (clr_done_q) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 9'd1;
          if (clr_addr_q == 9'd511) clr_done_d = 1'b1;
        end
      end
      StRun: begin
        if (hstart) line_d = ~line_q;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      clr_addr_q <= 9'd0;
      clr_done_q <= 1'b0;
      line_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_done_q <= clr_done_d;
      line_q     <= line_d;
      ready_q    <= ready_d;
    end
  end

  assign rd_en = (state_q == StRun) && pxl_cen;

  // Bank b is the write bank when line == b; otherwise its port only erases behind the reader.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      mem_we[b]    = 1'b0;
      mem_waddr[b] = clr_addr_q;
      mem_wdata[b] = Transp;
      if (state_q == StInit) begin
        mem_we[b] = ~clr_done_q;
      end else if (bf_we && (line_q == b[0])) begin
        mem_we[b]    = 1'b1;
        mem_waddr[b] = bf_addr;
        mem_wdata[b] = bf_data;
      end else if (rd_valid_q && (rd_bank_q == b[0])) begin
        mem_we[b]    = 1'b1;
        mem_waddr[b] = rd_addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we[0]) mem_a[mem_waddr[0]] <= mem_wdata[0];
    if (mem_we[1]) mem_b[mem_waddr[1]] <= mem_wdata[1];
    if (rd_en) begin
      rdata_a <= mem_a[hdump];
      rdata_b <= mem_b[hdump];
    end
  end

  // Stage 2 follows the bank latched with the read, so a swap in between does not redirect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_addr_q  <= 9'd0;
      rd_bank_q  <= 1'b0;
      pxl_q      <= Transp;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_addr_q <= hdump;
        rd_bank_q <= ~line_q;
      end
      if (rd_valid_q) pxl_q <= rd_bank_q ? rdata_b : rdata_a;
    end
  end

  assign pxl   = pxl_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_jts16_obj_buffer.sv
// Directed bench for jts16_obj_buffer: a bank model feeds an expected-pixel queue
// that is popped when each read's output becomes valid.
module tb_jts16_obj_buffer;

  localparam int unsigned DW = 12;
  localparam logic [DW-1:0] Ones = {DW{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hstart;
  logic [DW-1:0] bf_data;
  logic          bf_we;
  logic [8:0]    bf_addr;
  logic          pxl_cen;
  logic [8:0]    hdump;
  logic [DW-1:0] pxl;
  logic          ready;

  jts16_obj_buffer #(.DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hstart  (hstart),
    .bf_data (bf_data),
    .bf_we   (bf_we),
    .bf_addr (bf_addr),
    .pxl_cen (pxl_cen),
    .hdump   (hdump),
    .pxl     (pxl),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            addr;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] mdl [2][512];
  logic          mline;
  bit            mrun;
  bit            pend;
  int            vectors;
  int            miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) mdl[b][a] = Ones;
    mline = 1'b0;
  endtask

  // One clock of stimulus; compares the read issued on the previous step.
  task automatic step(input logic hs, input logic we, input logic [8:0] wa,
                      input logic [DW-1:0] wd, input logic cen, input logic [8:0] hd);
    exp_t e;
    @(negedge clk);
    hstart  = hs;
    bf_we   = we;
    bf_addr = wa;
    bf_data = wd;
    pxl_cen = cen;
    hdump   = hd;
    if (mrun) begin
      if (we) mdl[mline][wa] = wd;
      if (cen) begin
        e.addr = int'(hd);
        e.exp  = mdl[~mline][hd];
        sbq.push_back(e);
        mdl[~mline][hd] = Ones;
      end
      if (hs) mline = ~mline;
    end
    @(posedge clk);
    #1;
    if (pend) begin
      if (sbq.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        check($sformatf("pxl@%0d", e.addr), 32'(pxl), 32'(e.exp));
      end
    end
    pend = mrun && cen;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 9'd0, '0, 1'b0, 9'd0);
  endtask

  task automatic write(input logic [8:0] wa, input logic [DW-1:0] wd);
    step(1'b0, 1'b1, wa, wd, 1'b0, 9'd0);
  endtask

  task automatic swap();
    step(1'b1, 1'b0, 9'd0, '0, 1'b0, 9'd0);
  endtask

  task automatic scan(input int lo, input int hi);
    for (int x = lo; x <= hi; x++) step(1'b0, 1'b0, 9'd0, '0, 1'b1, 9'(x));
    idle();
  endtask

  // Called at a negedge with rst_n just released; pokes the ignored inputs during INIT.
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 600) begin
      bf_we   = (n < 8);
      bf_addr = 9'd5;
      bf_data = '0;
      hstart  = (n < 8);
      pxl_cen = (n < 8);
      hdump   = 9'd5;
      @(posedge clk);
      #1;
      n++;
      if (n == 10) check("init_pxl", 32'(pxl), 32'(Ones));
      if (!ready) @(negedge clk);
    end
    bf_we   = 1'b0;
    hstart  = 1'b0;
    pxl_cen = 1'b0;
    check("ready_latency", n, 513);
    model_clear();
    mrun = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mrun        = 1'b0;
    pend        = 1'b0;
    rst_n       = 1'b0;
    hstart      = 1'b0;
    bf_we       = 1'b0;
    bf_addr     = '0;
    bf_data     = '0;
    pxl_cen     = 1'b0;
    hdump       = '0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_pxl", 32'(pxl), 32'(Ones));
    check("rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();

    // Both banks cleared; INIT-time writes to x=5 dropped
    scan(0, 511);
    swap();
    scan(0, 511);

    // Basic line
    write(9'd10, 12'h123);
    write(9'd11, 12'h456);
    swap();
    scan(0, 319);

    // Erase-behind
    swap();
    swap();
    scan(0, 319);

    // Overwrite order
    write(9'd100, 12'h111);
    write(9'd100, 12'h222);
    swap();
    scan(95, 105);

    // Write coincident with swap lands on the next line
    step(1'b1, 1'b1, 9'd50, 12'h0AB, 1'b0, 9'd0);
    scan(48, 52);

    // Read coincident with swap uses the pre-swap read bank
    write(9'd60, 12'h3C3);
    swap();
    write(9'd60, 12'h5A5);
    step(1'b1, 1'b0, 9'd0, '0, 1'b1, 9'd60);
    scan(60, 60);

    // Async reset mid-scan
    write(9'd200, 12'h777);
    swap();
    write(9'd201, 12'h888);
    for (int x = 0; x <= 100; x++) step(1'b0, 1'b0, 9'd0, '0, 1'b1, 9'(x));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pxl", 32'(pxl), 32'(Ones));
    check("midrst_ready", 32'(ready), 32'd0);
    mrun = 1'b0;
    pend = 1'b0;
    sbq.delete();
    pxl_cen = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    scan(195, 205);
    swap();
    scan(195, 205);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
